// File: rtl/fpu_job_sequencer.sv
// fpu_job_sequencer
//   Accepts FPU jobs (four 32-bit operands plus a tag), queues them, issues
//   them to a pipelined FPU with single-cycle fpu_en pulses, pairs each
//   fpu_fi completion with the oldest outstanding tag, and buffers results
//   for a valid/ready consumer. Issue is throttled by an in-flight limit
//   (MAX_OUT), a result-buffer credit and a minimum issue spacing (MIN_GAP).
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready       job request handshake
//   cmd_a..cmd_d, cmd_tag     job operands and identifier
//   fpu_en, fpu_a..fpu_d      issue pulse and operands towards the FPU
//   fpu_fi, fpu_g             FPU completion pulse and result
//   res_valid/res_ready       result handshake
//   res_data, res_tag         result word and its job tag
//   busy, err                 activity flag, sticky spurious-completion flag
module fpu_job_sequencer #(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 4,
  parameter int MIN_GAP = 0,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [31:0]      cmd_c,
  input  logic [31:0]      cmd_d,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             fpu_en,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  output logic [31:0]      fpu_c,
  output logic [31:0]      fpu_d,
  input  logic             fpu_fi,
  input  logic [31:0]      fpu_g,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             busy,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;          // extra bit separates full from empty
  localparam int SW = AW + 2;          // room for outstanding + result occupancy
  localparam int CW = TAG_W + 128;     // command entry {tag, a, b, c, d}
  localparam int RW = TAG_W + 32;      // result entry {tag, g}

  localparam logic [PW-1:0] PTR_INC   = PW'(1);
  localparam logic [SW-1:0] DEPTH_S   = SW'(DEPTH);
  localparam logic [2:0]    MAX_OUT_S = 3'(MAX_OUT);
  localparam logic [3:0]    MIN_GAP_S = 4'(MIN_GAP);
  localparam logic [1:0]    TQ_LAST   = 2'(MAX_OUT - 1);

  // Tag queue index advance; the queue holds MAX_OUT entries, not a power of two.
  function automatic logic [1:0] tq_next(input logic [1:0] idx);
    if (idx == TQ_LAST) begin
      return 2'd0;
    end else begin
      return idx + 2'd1;
    end
  endfunction

  function automatic logic ptr_full(input logic [PW-1:0] wr, input logic [PW-1:0] rd);
    return (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  endfunction

  logic [CW-1:0]    cmd_mem_r [DEPTH];
  logic [PW-1:0]    cmd_wr_ptr_r, cmd_rd_ptr_r;
  logic [PW-1:0]    cmd_wr_ptr_nxt_s, cmd_rd_ptr_nxt_s;
  logic             cmd_push_s, cmd_empty_s, cmd_full_nxt_s, cmd_empty_nxt_s;
  logic [CW-1:0]    cmd_head_s;

  logic [2:0]       out_cnt_r, out_cnt_nxt_s;
  logic [TAG_W-1:0] tq_mem_r [4];
  logic [1:0]       tq_wr_r, tq_rd_r;

  logic [RW-1:0]    res_mem_r [DEPTH];
  logic [PW-1:0]    res_wr_ptr_r, res_rd_ptr_r;
  logic [PW-1:0]    res_wr_ptr_nxt_s, res_rd_ptr_nxt_s, res_cnt_s;
  logic             res_pop_s, res_empty_nxt_s;
  logic [RW-1:0]    res_push_word_s, res_head_nxt_s;

  logic [3:0]       gap_r, gap_nxt_s;
  logic             credit_s, issue_s, fi_ok_s;

  logic             cmd_ready_r, fpu_en_r, res_valid_r, busy_r, err_r;
  logic [31:0]      fpu_a_r, fpu_b_r, fpu_c_r, fpu_d_r, res_data_r;
  logic [TAG_W-1:0] res_tag_r;

  assign cmd_ready = cmd_ready_r;
  assign fpu_en    = fpu_en_r;
  assign fpu_a     = fpu_a_r;
  assign fpu_b     = fpu_b_r;
  assign fpu_c     = fpu_c_r;
  assign fpu_d     = fpu_d_r;
  assign res_valid = res_valid_r;
  assign res_data  = res_data_r;
  assign res_tag   = res_tag_r;
  assign busy      = busy_r;
  assign err       = err_r;

  // Current-cycle status: handshakes, credit and the issue decision.
  always_comb begin
    cmd_push_s  = cmd_valid && cmd_ready_r;
    cmd_empty_s = (cmd_wr_ptr_r == cmd_rd_ptr_r);
    cmd_head_s  = cmd_mem_r[cmd_rd_ptr_r[AW-1:0]];
    res_cnt_s   = res_wr_ptr_r - res_rd_ptr_r;
    res_pop_s   = res_valid_r && res_ready;
    // Every in-flight job must have a guaranteed slot in the result FIFO.
    credit_s    = (SW'(out_cnt_r) + SW'(res_cnt_s)) < DEPTH_S;
    issue_s     = !cmd_empty_s && (out_cnt_r < MAX_OUT_S) && credit_s && (gap_r == 4'd0);
    fi_ok_s     = fpu_fi && (out_cnt_r != 3'd0);
  end

  // Next-state values for pointers, counters and the result head.
  always_comb begin
    if (cmd_push_s) begin
      cmd_wr_ptr_nxt_s = cmd_wr_ptr_r + PTR_INC;
    end else begin
      cmd_wr_ptr_nxt_s = cmd_wr_ptr_r;
    end
    if (issue_s) begin
      cmd_rd_ptr_nxt_s = cmd_rd_ptr_r + PTR_INC;
    end else begin
      cmd_rd_ptr_nxt_s = cmd_rd_ptr_r;
    end
    cmd_full_nxt_s  = ptr_full(cmd_wr_ptr_nxt_s, cmd_rd_ptr_nxt_s);
    cmd_empty_nxt_s = (cmd_wr_ptr_nxt_s == cmd_rd_ptr_nxt_s);

    case ({issue_s, fi_ok_s})
      2'b10:   out_cnt_nxt_s = out_cnt_r + 3'd1;
      2'b01:   out_cnt_nxt_s = out_cnt_r - 3'd1;
      default: out_cnt_nxt_s = out_cnt_r;
    endcase

    if (issue_s) begin
      gap_nxt_s = MIN_GAP_S;
    end else if (gap_r != 4'd0) begin
      gap_nxt_s = gap_r - 4'd1;
    end else begin
      gap_nxt_s = 4'd0;
    end

    if (fi_ok_s) begin
      res_wr_ptr_nxt_s = res_wr_ptr_r + PTR_INC;
    end else begin
      res_wr_ptr_nxt_s = res_wr_ptr_r;
    end
    if (res_pop_s) begin
      res_rd_ptr_nxt_s = res_rd_ptr_r + PTR_INC;
    end else begin
      res_rd_ptr_nxt_s = res_rd_ptr_r;
    end
    res_empty_nxt_s = (res_wr_ptr_nxt_s == res_rd_ptr_nxt_s);
    res_push_word_s = {tq_mem_r[tq_rd_r], fpu_g};
    // The word being written this cycle becomes the head when nothing older remains.
    if (fi_ok_s && (res_wr_ptr_r == res_rd_ptr_nxt_s)) begin
      res_head_nxt_s = res_push_word_s;
    end else begin
      res_head_nxt_s = res_mem_r[res_rd_ptr_nxt_s[AW-1:0]];
    end
  end

  // Command FIFO storage and pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_wr_ptr_r <= {PW{1'b0}};
      cmd_rd_ptr_r <= {PW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        cmd_mem_r[i] <= {CW{1'b0}};
      end
    end else begin
      if (cmd_push_s) begin
        cmd_mem_r[cmd_wr_ptr_r[AW-1:0]] <= {cmd_tag, cmd_a, cmd_b, cmd_c, cmd_d};
      end
      cmd_wr_ptr_r <= cmd_wr_ptr_nxt_s;
      cmd_rd_ptr_r <= cmd_rd_ptr_nxt_s;
    end
  end

  // Issue pulse, held operands, gap counter and in-flight count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpu_en_r  <= 1'b0;
      fpu_a_r   <= 32'd0;
      fpu_b_r   <= 32'd0;
      fpu_c_r   <= 32'd0;
      fpu_d_r   <= 32'd0;
      gap_r     <= 4'd0;
      out_cnt_r <= 3'd0;
    end else begin
      fpu_en_r <= issue_s;
      if (issue_s) begin
        fpu_a_r <= cmd_head_s[127:96];
        fpu_b_r <= cmd_head_s[95:64];
        fpu_c_r <= cmd_head_s[63:32];
        fpu_d_r <= cmd_head_s[31:0];
      end
      gap_r     <= gap_nxt_s;
      out_cnt_r <= out_cnt_nxt_s;
    end
  end

  // In-order queue of tags for jobs inside the FPU.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tq_wr_r <= 2'd0;
      tq_rd_r <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        tq_mem_r[i] <= {TAG_W{1'b0}};
      end
    end else begin
      if (issue_s) begin
        tq_mem_r[tq_wr_r] <= cmd_head_s[CW-1:128];
        tq_wr_r           <= tq_next(tq_wr_r);
      end
      if (fi_ok_s) begin
        tq_rd_r <= tq_next(tq_rd_r);
      end
    end
  end

  // Result FIFO storage, pointers and registered head outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_wr_ptr_r <= {PW{1'b0}};
      res_rd_ptr_r <= {PW{1'b0}};
      res_valid_r  <= 1'b0;
      res_data_r   <= 32'd0;
      res_tag_r    <= {TAG_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        res_mem_r[i] <= {RW{1'b0}};
      end
    end else begin
      if (fi_ok_s) begin
        res_mem_r[res_wr_ptr_r[AW-1:0]] <= res_push_word_s;
      end
      res_wr_ptr_r <= res_wr_ptr_nxt_s;
      res_rd_ptr_r <= res_rd_ptr_nxt_s;
      res_valid_r  <= !res_empty_nxt_s;
      if (!res_empty_nxt_s) begin
        res_data_r <= res_head_nxt_s[31:0];
        res_tag_r  <= res_head_nxt_s[RW-1:32];
      end
    end
  end

  // Ready, busy and sticky error flags, registered from next-state occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      cmd_ready_r <= !cmd_full_nxt_s;
      busy_r      <= !cmd_empty_nxt_s || (out_cnt_nxt_s != 3'd0) || !res_empty_nxt_s;
      if (fpu_fi && !fi_ok_s) begin
        err_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fpu_job_sequencer.sv
// Directed bench for fpu_job_sequencer. A second instance with MIN_GAP=3
// shares the stimulus and is used for issue-spacing checks. The FPU stub
// returns a ^ b ^ c ^ d after a programmable latency.
module tb_fpu_job_sequencer;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_a, cmd_b, cmd_c, cmd_d;
  logic [3:0]  cmd_tag;
  logic        fpu_en;
  logic [31:0] fpu_a, fpu_b, fpu_c, fpu_d;
  logic        fpu_fi;
  logic [31:0] fpu_g;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic [3:0]  res_tag;
  logic        busy, err;

  logic        g_cmd_ready, g_fpu_en, g_res_valid, g_busy, g_err;
  logic [31:0] g_fpu_a, g_fpu_b, g_fpu_c, g_fpu_d, g_res_data;
  logic [3:0]  g_res_tag;

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned cyc = 0;
  int unsigned lat = 30;
  logic        spur_req = 1'b0;

  int unsigned due_q[$];
  logic [31:0] gval_q[$];
  int          en_cnt = 0;
  int unsigned en_t[$];
  int unsigned g_en_t[$];
  int          en_at_fi[$];
  logic [35:0] res_q[$];

  fpu_job_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c), .cmd_d(cmd_d), .cmd_tag(cmd_tag),
    .fpu_en(fpu_en), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_c(fpu_c), .fpu_d(fpu_d),
    .fpu_fi(fpu_fi), .fpu_g(fpu_g), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_tag(res_tag), .busy(busy), .err(err)
  );

  fpu_job_sequencer #(.MIN_GAP(3)) dut_g (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(g_cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c), .cmd_d(cmd_d), .cmd_tag(cmd_tag),
    .fpu_en(g_fpu_en), .fpu_a(g_fpu_a), .fpu_b(g_fpu_b), .fpu_c(g_fpu_c), .fpu_d(g_fpu_d),
    .fpu_fi(fpu_fi), .fpu_g(fpu_g), .res_valid(g_res_valid), .res_ready(res_ready),
    .res_data(g_res_data), .res_tag(g_res_tag), .busy(g_busy), .err(g_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  // FPU stub: records issues of the main instance and returns them in order.
  always @(negedge clk) begin
    if (!rst) begin
      due_q.delete();
      gval_q.delete();
      fpu_fi <= 1'b0;
      fpu_g  <= 32'd0;
    end else begin
      if (fpu_en) begin
        due_q.push_back(cyc + lat);
        gval_q.push_back(fpu_a ^ fpu_b ^ fpu_c ^ fpu_d);
      end
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        fpu_fi <= 1'b1;
        fpu_g  <= gval_q[0];
        void'(due_q.pop_front());
        void'(gval_q.pop_front());
      end else begin
        fpu_fi <= spur_req;
        fpu_g  <= 32'd0;
      end
    end
  end

  // Monitor: issue times, issue count at each completion, popped results.
  always @(posedge clk) begin
    if (rst) begin
      if (fpu_en) begin
        en_cnt <= en_cnt + 1;
        en_t.push_back(cyc);
      end
      if (g_fpu_en) g_en_t.push_back(cyc);
      if (fpu_fi) en_at_fi.push_back(en_cnt);
      if (res_valid && res_ready) res_q.push_back({res_tag, res_data});
    end
  end

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ja(input int k); return 32'h1000_0000 + 32'(k); endfunction
  function automatic logic [31:0] jb(input int k); return 32'(k) << 8; endfunction
  function automatic logic [31:0] jc(input int k); return 32'hA5A5_0000 | 32'(k); endfunction
  function automatic logic [31:0] jd(input int k); return 32'h0000_7700 + 32'(k * 3); endfunction
  function automatic logic [31:0] jg(input int k); return ja(k) ^ jb(k) ^ jc(k) ^ jd(k); endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                      input logic [31:0] d, input logic [3:0] tag);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_a = a; cmd_b = b; cmd_c = c; cmd_d = d; cmd_tag = tag;
    while (!cmd_ready && n < 60) begin
      tick();
      n++;
    end
    if (!cmd_ready) check_eq("send_timeout", cmd_ready, 1'b1);
    else tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send_job(input int k);
    send(ja(k), jb(k), jc(k), jd(k), 4'(k));
  endtask

  task automatic wait_results(input string name, input int n, input int bound);
    int k;
    k = 0;
    while (res_q.size() < n && k < bound) begin
      tick();
      k++;
    end
    check_eq(name, res_q.size() >= n, 1'b1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int en_base, fi_base, r_base, ei, gi, k;
    rst = 1'b0; cmd_valid = 1'b0; cmd_a = 32'd0; cmd_b = 32'd0; cmd_c = 32'd0;
    cmd_d = 32'd0; cmd_tag = 4'd0; res_ready = 1'b0;

    // Reset state and ready rising right after release
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_cmd_ready", cmd_ready, 1'b0);
    check_eq("rst_fpu_en", fpu_en, 1'b0);
    check_eq("rst_res_valid", res_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_err", err, 1'b0);
    rst = 1'b1;
    check_eq("release_ready_low", cmd_ready, 1'b0);
    tick();
    check_eq("release_ready_high", cmd_ready, 1'b1);

    // Single job 1.0, 2.0 -> 3.0 with tag 3
    lat = 30;
    en_base = en_cnt;
    send(32'h3F80_0000, 32'h4000_0000, 32'h0000_0000, 32'h3FC0_0000, 4'd3);
    k = 0;
    while (!res_valid && k < 80) begin tick(); k++; end
    check_eq("t1_res_valid", res_valid, 1'b1);
    check_eq("t1_res_data", res_data, 32'h4040_0000);
    check_eq("t1_res_tag", res_tag, 4'd3);
    check_eq("t1_issues", en_cnt - en_base, 1);
    check_eq("t1_fpu_a_held", fpu_a, 32'h3F80_0000);
    check_eq("t1_fpu_b_held", fpu_b, 32'h4000_0000);
    check_eq("t1_busy", busy, 1'b1);
    res_ready = 1'b1;
    tick();
    check_eq("t1_res_drained", res_valid, 1'b0);
    check_eq("t1_idle", busy, 1'b0);

    // Six jobs back to back: four in flight before the first completion
    en_base = en_cnt; fi_base = en_at_fi.size(); r_base = res_q.size();
    for (int j = 0; j < 6; j++) send_job(j);
    wait_results("t2_done", r_base + 6, 300);
    if (en_at_fi.size() > fi_base) check_eq("t2_en_before_fi", en_at_fi[fi_base] - en_base, 4);
    for (int j = 0; j < 6; j++) begin
      check_eq($sformatf("t2_res_%0d", j), res_q[r_base + j], {4'(j), jg(j)});
    end
    check_eq("t2_issues", en_cnt - en_base, 6);
    check_eq("t2_err", err, 1'b0);

    // Result FIFO full with res_ready low blocks issue and then intake
    res_ready = 1'b0;
    lat = 5;
    en_base = en_cnt; r_base = res_q.size();
    for (int j = 8; j < 12; j++) send_job(j);
    repeat (20) tick();
    check_eq("t3_issues_held", en_cnt - en_base, 4);
    check_eq("t3_res_valid", res_valid, 1'b1);
    check_eq("t3_head_tag", res_tag, 4'd8);
    for (int j = 12; j < 16; j++) send_job(j);
    check_eq("t3_cmd_full", cmd_ready, 1'b0);
    repeat (10) tick();
    check_eq("t3_no_issue", en_cnt - en_base, 4);
    check_eq("t3_head_stable_tag", res_tag, 4'd8);
    check_eq("t3_head_stable_data", res_data, jg(8));
    res_ready = 1'b1;
    wait_results("t3_done", r_base + 8, 200);
    for (int j = 0; j < 8; j++) begin
      check_eq($sformatf("t3_res_%0d", j + 8), res_q[r_base + j], {4'(j + 8), jg(j + 8)});
    end
    check_eq("t3_issues", en_cnt - en_base, 8);

    // Issue spacing: MIN_GAP=0 back to back, MIN_GAP=3 four cycles apart
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    ei = en_t.size(); gi = g_en_t.size();
    for (int j = 1; j < 4; j++) send_job(j);
    repeat (20) tick();
    check_eq("t4_gap_count", g_en_t.size() - gi, 3);
    if (g_en_t.size() >= gi + 3) begin
      check_eq("t4_gap_1", g_en_t[gi + 1] - g_en_t[gi], 4);
      check_eq("t4_gap_2", g_en_t[gi + 2] - g_en_t[gi + 1], 4);
    end
    if (en_t.size() >= ei + 3) begin
      check_eq("t4_b2b_1", en_t[ei + 1] - en_t[ei], 1);
      check_eq("t4_b2b_2", en_t[ei + 2] - en_t[ei + 1], 1);
    end

    // Spurious completion, then reset with two jobs in flight
    k = 0;
    while (busy && k < 100) begin tick(); k++; end
    check_eq("t5_idle", busy, 1'b0);
    spur_req = 1'b1;
    tick();
    spur_req = 1'b0;
    check_eq("t5_err_set", err, 1'b1);
    check_eq("t5_no_result", res_valid, 1'b0);
    tick();
    check_eq("t5_no_result_later", res_valid, 1'b0);
    lat = 30;
    en_base = en_cnt;
    send_job(4);
    send_job(5);
    repeat (4) tick();
    check_eq("t5_in_flight", en_cnt - en_base, 2);
    check_eq("t5_busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    check_eq("t5_rst_cmd_ready", cmd_ready, 1'b0);
    check_eq("t5_rst_fpu_en", fpu_en, 1'b0);
    check_eq("t5_rst_fpu_ops", {fpu_a | fpu_b, fpu_c | fpu_d}, 64'd0);
    check_eq("t5_rst_res_valid", res_valid, 1'b0);
    check_eq("t5_rst_res_data", res_data, 32'd0);
    check_eq("t5_rst_res_tag", res_tag, 4'd0);
    check_eq("t5_rst_busy", busy, 1'b0);
    check_eq("t5_rst_err", err, 1'b0);
    check_eq("t5_rst_g_flags", {g_cmd_ready, g_fpu_en, g_res_valid, g_busy, g_err}, 5'd0);
    check_eq("t5_rst_g_ops", {g_fpu_a | g_fpu_b, g_fpu_c | g_fpu_d}, 64'd0);
    check_eq("t5_rst_g_res", {g_res_tag, g_res_data}, 36'd0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check_eq("t5_post_ready", cmd_ready, 1'b1);
    check_eq("t5_post_busy", busy, 1'b0);
    repeat (40) tick();
    check_eq("t5_post_err", err, 1'b0);
    check_eq("t5_post_res_valid", res_valid, 1'b0);
    spur_req = 1'b1;
    tick();
    spur_req = 1'b0;
    check_eq("t5_post_spur_err", err, 1'b1);
    check_eq("t5_post_spur_res", res_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_job_sequencer.md
FPU_JOB_SEQUENCER -- requirements
Module: fpu_job_sequencer

Interface
REQ-001 Parameter DEPTH, default 4: command FIFO depth and result FIFO depth, power of two, 2 to 16.
REQ-002 Parameter MAX_OUT, default 4: maximum jobs in flight inside the FPU, 1 to 4.
REQ-003 Parameter MIN_GAP, default 0: minimum idle cycles between consecutive fpu_en pulses, 0 to 15.
REQ-004 Parameter TAG_W, default 4: job tag width.
REQ-005 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-low reset; assertion (rst=0) clears state immediately; deassertion is synchronous to clk.
REQ-007 Ports cmd_valid/cmd_ready, input/output, 1/1: job request handshake.
REQ-008 Ports cmd_a, cmd_b, cmd_c, cmd_d, input, 32 each: job operands.
REQ-009 Port cmd_tag, input, TAG_W: job identifier, returned with the result.
REQ-010 Ports fpu_en, output, 1: single-cycle issue pulse to the FPU.
REQ-011 Ports fpu_a, fpu_b, fpu_c, fpu_d, output, 32 each: operands to the FPU.
REQ-012 Ports fpu_fi, input, 1, and fpu_g, input, 32: FPU finish pulse and result.
REQ-013 Ports res_valid/res_ready, output/input, 1/1: result handshake.
REQ-014 Ports res_data, output, 32, and res_tag, output, TAG_W: result and its job tag.
REQ-015 Ports busy, output, 1, and err, output, 1: activity flag and sticky protocol-error flag.

Function
REQ-016 A command transfers when cmd_valid=1 and cmd_ready=1; cmd_ready=1 exactly when the command FIFO is not full; a push while full is impossible.
REQ-017 Issue occurs in a cycle where all hold: command FIFO non-empty, outstanding<MAX_OUT, outstanding+result-FIFO occupancy<DEPTH, and at least MIN_GAP idle cycles since the last issue.
REQ-018 fpu_en is registered; a command accepted in cycle N into an empty FIFO drives fpu_en=1 in cycle N+1 at the earliest.
REQ-019 In the fpu_en cycle, fpu_a..fpu_d carry the issued job's operands; they hold that value until the next issue.
REQ-020 On issue, the job tag is pushed into an in-order outstanding-tag queue of depth MAX_OUT, and outstanding increments.
REQ-021 Each fpu_fi=1 completes the oldest outstanding job: {fpu_g, oldest tag} is pushed to the result FIFO, and outstanding decrements.
REQ-022 Issue and fpu_fi in the same cycle leave outstanding unchanged; both queue operations take effect.
REQ-023 fpu_fi=1 with outstanding=0 is ignored (no push), and err is set to 1 until reset.
REQ-024 Result FIFO: res_valid=1 when non-empty; res_data/res_tag show the head entry and stay stable while res_valid=1 and res_ready=0.
REQ-025 A result captured in cycle M appears with res_valid=1 in cycle M+1 when the result FIFO was empty.
REQ-026 Push and pop of the result FIFO in the same cycle are both honoured; the credit rule of REQ-017 guarantees no overflow.
REQ-027 Results return in issue order; tags are never reordered.
REQ-028 MIN_GAP counter: loaded with MIN_GAP on issue, decrements to 0 each cycle; issue is allowed only at 0; MIN_GAP=0 permits back-to-back fpu_en.
REQ-029 busy=1 when the command FIFO is non-empty, outstanding>0, or the result FIFO is non-empty.
REQ-030 FIFO pointers wrap modulo DEPTH; full/empty are distinguished by an extra pointer bit.

Reset
REQ-031 While rst=0: cmd_ready=0, fpu_en=0, fpu_a..fpu_d=0, res_valid=0, res_data=0, res_tag=0, busy=0, err=0; all FIFOs empty; outstanding=0; gap counter=0.
REQ-032 Reset mid-operation discards all queued, in-flight, and unread jobs; fpu_fi pulses after reset release count as spurious (REQ-023).
REQ-033 cmd_ready rises in the first cycle after rst deasserts.

Verification
REQ-034 Single job a=1.0, b=2.0, tag=3; model returns fi after 30 cycles with g=0x40400000 -> one fpu_en pulse, then res_valid with res_data=0x40400000 and res_tag=3.
REQ-035 Six back-to-back jobs, tags 0-5, MAX_OUT=4, res_ready=1 -> exactly four fpu_en before the first fi; tags return in order 0..5; err=0.
REQ-036 res_ready=0 with four results held and DEPTH=4 -> no further fpu_en; cmd_ready=0 after four more commands are queued; releasing res_ready resumes issue.
REQ-037 MIN_GAP=3, three queued jobs -> fpu_en pulses exactly 4 cycles apart.
REQ-038 fpu_fi with nothing outstanding -> err=1, no res_valid; then rst=0 mid-flight with two jobs outstanding -> all outputs zero, err=0, busy=0.
